// File: rtl/multdiv_if.sv
// Operand, control and result bundle shared by the execute stage and multdiv.
// The execute stage is the master and the multiplier/divider is the slave.
interface multdiv_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv.sv
// Multi-cycle signed 32-bit multiplier (radix-2 Booth) and divider (restoring).
// Each operation takes 32 iteration cycles plus one DONE cycle that publishes the result.
module multdiv (
    input logic     clock,
    input logic     reset,
    multdiv_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [5:0]  count;
    logic        opIsDiv;
    logic [64:0] prodReg;
    logic [31:0] mcand;
    logic [32:0] remReg;
    logic [31:0] quoReg;
    logic [31:0] divisorMag;
    logic        negateQuo;
    logic        divByZero;
    logic        divOverflow;

    logic        startMult;
    logic        startDiv;
    logic [32:0] boothSum;
    logic [33:0] divShifted;
    logic [33:0] divDiff;
    logic        divFits;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] finalResult;
    logic        finalExc;

    assign startMult = bus.ctrl_MULT & ~bus.ctrl_DIV;
    assign startDiv  = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign magA = bus.data_operandA[31] ? -bus.data_operandA : bus.data_operandA;
    assign magB = bus.data_operandB[31] ? -bus.data_operandB : bus.data_operandB;

    // The Booth add is one bit wider than the accumulator so that subtracting
    // the most negative multiplicand cannot wrap before the arithmetic shift.
    always_comb begin
        boothSum = {prodReg[64], prodReg[64:33]};
        case (prodReg[1:0])
            2'b01:   boothSum = {prodReg[64], prodReg[64:33]} + {mcand[31], mcand};
            2'b10:   boothSum = {prodReg[64], prodReg[64:33]} - {mcand[31], mcand};
            default: boothSum = {prodReg[64], prodReg[64:33]};
        endcase
    end

    always_comb begin
        divShifted = {remReg, quoReg[31]};
        divDiff    = divShifted - {2'b00, divisorMag};
        divFits    = ~divDiff[33];
    end

    always_comb begin
        finalResult = prodReg[32:1];
        finalExc    = ~((&prodReg[64:32]) | ~(|prodReg[64:32]));
        if (opIsDiv) begin
            finalResult = divByZero ? 32'd0 : (negateQuo ? -quoReg : quoReg);
            finalExc    = divByZero | divOverflow;
        end
    end

    // A start pulse is handled last so it overrides any iteration or DONE
    // bookkeeping in the same cycle, while still letting a DONE pulse go out.
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            count              <= 6'd0;
            opIsDiv            <= 1'b0;
            prodReg            <= 65'd0;
            mcand              <= 32'd0;
            remReg             <= 33'd0;
            quoReg             <= 32'd0;
            divisorMag         <= 32'd0;
            negateQuo          <= 1'b0;
            divByZero          <= 1'b0;
            divOverflow        <= 1'b0;
            bus.data_result    <= 32'd0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            bus.data_resultRDY <= 1'b0;
            case (state)
                MULT: begin
                    prodReg <= {boothSum, prodReg[32:1]};
                    count   <= count + 6'd1;
                    if (count == 6'd31) state <= DONE;
                end
                DIV: begin
                    remReg <= divFits ? divDiff[32:0] : divShifted[32:0];
                    quoReg <= {quoReg[30:0], divFits};
                    count  <= count + 6'd1;
                    if (count == 6'd31) state <= DONE;
                end
                DONE: begin
                    bus.data_result    <= finalResult;
                    bus.data_exception <= finalExc;
                    bus.data_resultRDY <= 1'b1;
                    bus.busy           <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (startMult || startDiv) begin
                count       <= 6'd0;
                bus.busy    <= 1'b1;
                opIsDiv     <= startDiv;
                state       <= startDiv ? DIV : MULT;
                mcand       <= bus.data_operandA;
                prodReg     <= {32'd0, bus.data_operandB, 1'b0};
                remReg      <= 33'd0;
                quoReg      <= magA;
                divisorMag  <= magB;
                negateQuo   <= bus.data_operandA[31] ^ bus.data_operandB[31];
                divByZero   <= (bus.data_operandB == 32'd0);
                divOverflow <= (bus.data_operandA == 32'h8000_0000) &&
                               (bus.data_operandB == 32'hFFFF_FFFF);
            end
        end
    end

endmodule

// File: tb/tb_multdiv.sv
// Directed bench for multdiv: hand-computed products and quotients, latency,
// abort-on-restart and mid-operation reset behaviour.
module tb_multdiv;

    logic clock;
    logic reset;
    int   vectorCount;
    int   missCount;
    int   cycles;
    logic rdySeen;

    multdiv_if mdBus ();

    multdiv dut (
        .clock (clock),
        .reset (reset),
        .bus   (mdBus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Pulses a start strobe so that it is sampled at exactly one rising edge.
    task automatic applyStimulus(input logic doMult, input logic doDiv,
                                 input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        mdBus.data_operandA = a;
        mdBus.data_operandB = b;
        mdBus.ctrl_MULT     = doMult;
        mdBus.ctrl_DIV      = doDiv;
        @(posedge clock);
        #1;
        mdBus.ctrl_MULT     = 1'b0;
        mdBus.ctrl_DIV      = 1'b0;
        mdBus.data_operandA = 32'hDEAD_BEEF;
        mdBus.data_operandB = 32'h1234_5678;
    endtask

    task automatic waitRdy(output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!mdBus.data_resultRDY && n < 60);
    endtask

    task automatic runOp(input string tag, input logic doDiv,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input logic expExc);
        int n;
        applyStimulus(~doDiv, doDiv, a, b);
        checkOutput({tag, " busy after start"}, {31'd0, mdBus.busy}, 32'd1);
        waitRdy(n);
        checkOutput({tag, " latency"}, n, 32'd33);
        checkOutput({tag, " result"}, mdBus.data_result, expRes);
        checkOutput({tag, " exception"}, {31'd0, mdBus.data_exception}, {31'd0, expExc});
        checkOutput({tag, " busy at rdy"}, {31'd0, mdBus.busy}, 32'd0);
        @(posedge clock);
        #1;
        checkOutput({tag, " rdy one cycle"}, {31'd0, mdBus.data_resultRDY}, 32'd0);
        checkOutput({tag, " result held"}, mdBus.data_result, expRes);
    endtask

    initial begin
        vectorCount         = 0;
        missCount           = 0;
        reset               = 1'b1;
        mdBus.data_operandA = 32'd0;
        mdBus.data_operandB = 32'd0;
        mdBus.ctrl_MULT     = 1'b0;
        mdBus.ctrl_DIV      = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("reset result", mdBus.data_result, 32'd0);
        checkOutput("reset exception", {31'd0, mdBus.data_exception}, 32'd0);
        checkOutput("reset rdy", {31'd0, mdBus.data_resultRDY}, 32'd0);
        checkOutput("reset busy", {31'd0, mdBus.busy}, 32'd0);

        // Both strobes high together must be ignored.
        applyStimulus(1'b1, 1'b1, 32'd3, 32'd3);
        checkOutput("both strobes ignored", {31'd0, mdBus.busy}, 32'd0);

        runOp("mul 7*-3",        1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        runOp("mul 2^16*2^16",   1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
        runOp("mul min*1",       1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
        runOp("mul -6*-7",       1'b0, 32'hFFFF_FFFA,  32'hFFFF_FFF9, 32'd42,        1'b0);
        runOp("div -7/2",        1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
        runOp("div min/-1",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        runOp("div 5/0",         1'b1, 32'd5,          32'd0,         32'd0,         1'b1);
        runOp("div -100/7",      1'b1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0);

        // A DIV strobe ten cycles into a MULT aborts the MULT without a pulse.
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd4);
        rdySeen = 1'b0;
        repeat (9) begin
            @(posedge clock);
            #1;
            rdySeen = rdySeen | mdBus.data_resultRDY;
        end
        applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
        checkOutput("abort no early rdy", {31'd0, rdySeen}, 32'd0);
        waitRdy(cycles);
        checkOutput("abort div latency", cycles, 32'd33);
        checkOutput("abort div result", mdBus.data_result, 32'd14);
        checkOutput("abort div exception", {31'd0, mdBus.data_exception}, 32'd0);

        // Reset five cycles into a DIV discards it and clears the outputs.
        applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("midreset result", mdBus.data_result, 32'd0);
        checkOutput("midreset exception", {31'd0, mdBus.data_exception}, 32'd0);
        checkOutput("midreset rdy", {31'd0, mdBus.data_resultRDY}, 32'd0);
        checkOutput("midreset busy", {31'd0, mdBus.busy}, 32'd0);
        rdySeen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            rdySeen = rdySeen | mdBus.data_resultRDY | mdBus.busy;
        end
        checkOutput("midreset stays idle", {31'd0, rdySeen}, 32'd0);
        runOp("mul 6*7 after reset", 1'b0, 32'd6, 32'd7, 32'd42, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
